// File: rtl/pipelined_conditional_sum_adder.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready handshake on both sides.
// Optional signed-overflow output is enabled by defining CSA_OVERFLOW_EN.
module pipelined_conditional_sum_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CSA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT    = LEVELS + 1;

  logic             adv;
  logic [LAT-2:0]   stage_valid;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Per-bit pair (sum, carry-out of the bit within its block) for block carry-in 0 and 1
  logic [WIDTH-1:0] s0_q [LEVELS];
  logic [WIDTH-1:0] s1_q [LEVELS];
  logic [WIDTH-1:0] c0_q [LEVELS];
  logic [WIDTH-1:0] c1_q [LEVELS];
  logic [WIDTH-1:0] s0_d [LEVELS];
  logic [WIDTH-1:0] s1_d [LEVELS];
  logic [WIDTH-1:0] c0_d [LEVELS];
  logic [WIDTH-1:0] c1_d [LEVELS];

`ifdef CSA_OVERFLOW_EN
  logic ovf_q;
  logic msb_cin_d;
`endif

  function automatic int low_top(input int i, input int k);
    return ((i >> k) << k) + (1 << (k - 1)) - 1;
  endfunction

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CSA_OVERFLOW_EN
  assign ovf       = ovf_q & out_valid_q;
`endif

  always_comb begin
    y_eff   = sub ? ~y : y;
    cin_eff = cin ^ sub;

    s0_d[0] = x ^ y_eff;
    s1_d[0] = ~(x ^ y_eff);
    c0_d[0] = x & y_eff;
    c1_d[0] = x | y_eff;
    // Bit 0 sees the real carry-in, so block 0 is resolved from level 0 onward
    s0_d[0][0] = x[0] ^ y_eff[0] ^ cin_eff;
    s1_d[0][0] = s0_d[0][0];
    c0_d[0][0] = (x[0] & y_eff[0]) | (cin_eff & (x[0] ^ y_eff[0]));
    c1_d[0][0] = c0_d[0][0];

    for (int k = 1; k < LEVELS; k++) begin
      s0_d[k] = s0_q[k-1];
      s1_d[k] = s1_q[k-1];
      c0_d[k] = c0_q[k-1];
      c1_d[k] = c1_q[k-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> (k - 1)) & 1) != 0) begin
          s0_d[k][i] = c0_q[k-1][low_top(i, k)] ? s1_q[k-1][i] : s0_q[k-1][i];
          c0_d[k][i] = c0_q[k-1][low_top(i, k)] ? c1_q[k-1][i] : c0_q[k-1][i];
          s1_d[k][i] = c1_q[k-1][low_top(i, k)] ? s1_q[k-1][i] : s0_q[k-1][i];
          c1_d[k][i] = c1_q[k-1][low_top(i, k)] ? c1_q[k-1][i] : c0_q[k-1][i];
        end
      end
    end

    sum_d = s0_q[LEVELS-1];
    for (int i = WIDTH / 2; i < WIDTH; i++) begin
      sum_d[i] = c0_q[LEVELS-1][WIDTH/2-1] ? s1_q[LEVELS-1][i] : s0_q[LEVELS-1][i];
    end
    cout_d = c0_q[LEVELS-1][WIDTH/2-1] ? c1_q[LEVELS-1][WIDTH-1] : c0_q[LEVELS-1][WIDTH-1];
`ifdef CSA_OVERFLOW_EN
    msb_cin_d = c0_q[LEVELS-1][WIDTH/2-1] ? c1_q[LEVELS-1][WIDTH-2] : c0_q[LEVELS-1][WIDTH-2];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      stage_valid[0] <= in_valid;
      for (int k = 1; k < LEVELS; k++) begin
        stage_valid[k] <= stage_valid[k-1];
      end
      out_valid_q <= stage_valid[LEVELS-1];
    end
  end

  // Data registers only load under a valid beat so bubbles leave them untouched
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        s0_q[0] <= s0_d[0];
        s1_q[0] <= s1_d[0];
        c0_q[0] <= c0_d[0];
        c1_q[0] <= c1_d[0];
      end
      for (int k = 1; k < LEVELS; k++) begin
        if (stage_valid[k-1]) begin
          s0_q[k] <= s0_d[k];
          s1_q[k] <= s1_d[k];
          c0_q[k] <= c0_d[k];
          c1_q[k] <= c1_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef CSA_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else if (adv && stage_valid[LEVELS-1]) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
`ifdef CSA_OVERFLOW_EN
      ovf_q  <= msb_cin_d ^ cout_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_conditional_sum_adder.sv
// Self-checking bench for pipelined_conditional_sum_adder (WIDTH=16): directed cases plus random traffic
// against an arithmetic reference model; ovf is checked when CSA_OVERFLOW_EN is defined.
module tb_pipelined_conditional_sum_adder;

  localparam int W   = 16;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_OVERFLOW_EN
  logic         ovf;
`endif

  int checks   = 0;
  int errors   = 0;
  int rx_count = 0;
  int n;
  int sent;
  int rx0;

  logic [W+1:0] exp_q[$];
  logic         held_valid = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  logic [W-1:0] rx_x, rx_y;
  logic         rx_c, rx_s;

  pipelined_conditional_sum_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CSA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain add, or subtract with borrow turned into cout; ovf from the signed result range
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W:0]          u;
    logic [W:0]          d;
    logic signed [W+1:0] sg;
    logic                of;
    if (!s) begin
      u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      sg = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
    end else begin
      d  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
      u  = {~d[W], d[W-1:0]};
      sg = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b}) - $signed({{(W+1){1'b0}}, c});
    end
    of = (sg[W+1:W-1] != 3'b000) && (sg[W+1:W-1] != 3'b111);
    return {of, u};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive after the falling edge, then check handshake and outputs before the rising edge
  task automatic step(input logic r, input logic iv, input logic [W-1:0] ix, input logic [W-1:0] iy,
                      input logic ic, input logic is, input logic ordy);
    logic [W+1:0] e;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    x         = ix;
    y         = iy;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    if (r) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", sum, held_sum);
        chk("hold_cout", cout, held_cout);
      end
`ifdef CSA_OVERFLOW_EN
      if (!out_valid) chk("ovf_idle", ovf, 1'b0);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          rx_count++;
          chk("sum", sum, e[W-1:0]);
          chk("cout", cout, e[W]);
`ifdef CSA_OVERFLOW_EN
          chk("ovf", ovf, e[W+1]);
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ix, iy, ic, is));
      held_valid = out_valid && !out_ready;
      held_sum   = sum;
      held_cout  = cout;
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cyc++;
    end while (!out_valid && cyc < 20);
  endtask

  task automatic new_operands();
    logic [31:0] r;
    r = $urandom;
    rx_x = r[W-1:0];
    r = $urandom;
    rx_y = r[W-1:0];
    rx_c = 1'($urandom_range(0, 1));
    rx_s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: rx_x = '1;
      1: rx_y = {1'b1, {(W-1){1'b0}}};
      2: rx_x = {1'b1, {(W-1){1'b0}}};
      3: rx_y = '0;
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Reset with a beat offered: it must be dropped and outputs cleared
    step(1'b1, 1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Add wrap-around and latency
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_out(n);
    chk("t2_latency", n, LAT);
    chk("t2_sum", sum, 16'h0000);
    chk("t2_cout", cout, 1'b1);
`ifdef CSA_OVERFLOW_EN
    chk("t2_ovf", ovf, 1'b0);
`endif

    // Subtract with borrow, then signed overflow on subtract
    step(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    wait_out(n);
    chk("t3a_sum", sum, 16'hFFFE);
    chk("t3a_cout", cout, 1'b0);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    wait_out(n);
    chk("t3b_sum", sum, 16'h7FFF);
    chk("t3b_cout", cout, 1'b1);
`ifdef CSA_OVERFLOW_EN
    chk("t3b_ovf", ovf, 1'b1);
`endif

    // 20-beat stream with the sink stalling in cycles 8..11
    rx0  = rx_count;
    sent = 0;
    new_operands();
    for (int c = 0; c < 60 && (sent < 20 || exp_q.size() != 0); c++) begin
      step(1'b0, sent < 20, rx_x, rx_y, rx_c, rx_s, !(c >= 8 && c <= 11));
      if (c >= 8 && c <= 11) chk("t4_in_ready_low", in_ready, 1'b0);
      if (sent < 20 && in_ready) begin
        sent++;
        new_operands();
      end
    end
    chk("t4_received", rx_count - rx0, 20);

    // Reset with beats in flight, then a clean beat afterwards
    step(1'b0, 1'b1, 16'd10, 16'd11, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd12, 16'd13, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd14, 16'd15, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b1);
    wait_out(n);
    chk("t5_latency", n, LAT);
    chk("t5_sum", sum, 16'd5);

    // Random traffic with random valid/ready
    for (int c = 0; c < 3000; c++) begin
      new_operands();
      step(1'b0, $urandom_range(0, 9) < 7, rx_x, rx_y, rx_c, rx_s, $urandom_range(0, 9) < 7);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
